// File: rtl/rptr_level_ctrl.sv
// Read-side pointer controller for an async FIFO: synchronises the write gray pointer,
// tracks the read pointer, and produces empty/level/underflow in standard or FWFT mode.
module rptr_level_ctrl #(
    parameter int PTR_WIDTH   = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 2,
    parameter bit FWFT        = 1'b0
) (
    input  logic               rclk,
    input  logic               r_rstn,
    input  logic               re,
    input  logic [PTR_WIDTH:0] g_wptr,
    output logic [PTR_WIDTH:0] b_rptr,
    output logic [PTR_WIDTH:0] g_rptr,
    output logic               mem_re,
    output logic               rvalid,
    output logic               empty,
    output logic               almost_empty,
    output logic [PTR_WIDTH:0] rd_level,
    output logic               underflow
);
    localparam int PW1 = PTR_WIDTH + 1;
    localparam logic [PTR_WIDTH:0] AE_LEVEL = PW1'(AE_THRESH);

    logic [PTR_WIDTH:0] sync_reg [SYNC_STAGES];
    logic [PTR_WIDTH:0] g_wptr_s;
    logic [PTR_WIDTH:0] b_wptr_s;

    logic [PTR_WIDTH:0] b_rptr_reg, b_rptr_next;
    logic [PTR_WIDTH:0] g_rptr_reg, g_rptr_next;
    logic [PTR_WIDTH:0] level_reg, level_next;
    logic               rvalid_reg, rvalid_next;
    logic               empty_reg, empty_next;
    logic               ae_reg, ae_next;
    logic               underflow_reg, underflow_next;

    always_ff @(posedge rclk or negedge r_rstn) begin
        if (!r_rstn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= '0;
            end
        end else begin
            sync_reg[0] <= g_wptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    assign g_wptr_s = sync_reg[SYNC_STAGES-1];

    // Each binary bit is the XOR of all gray bits at and above it.
    generate
        for (genvar gi = 0; gi <= PTR_WIDTH; gi++) begin : g_gray2bin
            assign b_wptr_s[gi] = ^g_wptr_s[PTR_WIDTH:gi];
        end
    endgenerate

    always_comb begin
        mem_re      = 1'b0;
        b_rptr_next = b_rptr_reg;
        rvalid_next = rvalid_reg;
        g_rptr_next = g_rptr_reg;
        level_next  = level_reg;
        empty_next  = empty_reg;
        if (FWFT) begin
            // Prefetch whenever the output register is free or being consumed.
            mem_re      = (g_rptr_reg != g_wptr_s) & (~rvalid_reg | re);
            rvalid_next = mem_re ? 1'b1 : (re ? 1'b0 : rvalid_reg);
            b_rptr_next = b_rptr_reg + {{PTR_WIDTH{1'b0}}, mem_re};
            g_rptr_next = b_rptr_next ^ (b_rptr_next >> 1);
            level_next  = (b_wptr_s - b_rptr_next) + {{PTR_WIDTH{1'b0}}, rvalid_next};
            empty_next  = ~rvalid_next;
        end else begin
            mem_re      = re & ~empty_reg;
            rvalid_next = mem_re;
            b_rptr_next = b_rptr_reg + {{PTR_WIDTH{1'b0}}, mem_re};
            g_rptr_next = b_rptr_next ^ (b_rptr_next >> 1);
            level_next  = b_wptr_s - b_rptr_next;
            empty_next  = (g_rptr_next == g_wptr_s);
        end
        ae_next        = (level_next <= AE_LEVEL);
        underflow_next = re & empty_reg;
    end

    always_ff @(posedge rclk or negedge r_rstn) begin
        if (!r_rstn) begin
            b_rptr_reg    <= '0;
            g_rptr_reg    <= '0;
            level_reg     <= '0;
            rvalid_reg    <= 1'b0;
            empty_reg     <= 1'b1;
            ae_reg        <= 1'b1;
            underflow_reg <= 1'b0;
        end else begin
            b_rptr_reg    <= b_rptr_next;
            g_rptr_reg    <= g_rptr_next;
            level_reg     <= level_next;
            rvalid_reg    <= rvalid_next;
            empty_reg     <= empty_next;
            ae_reg        <= ae_next;
            underflow_reg <= underflow_next;
        end
    end

    assign b_rptr       = b_rptr_reg;
    assign g_rptr       = g_rptr_reg;
    assign rvalid       = rvalid_reg;
    assign empty        = empty_reg;
    assign almost_empty = ae_reg;
    assign rd_level     = level_reg;
    assign underflow    = underflow_reg;

endmodule
